// File: rtl/fp8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp8_pkg
//  Description : Shared constants, FSM state encoding and reference decode
//                function for the 8-bit {S, E[2:0], F[3:0]} float format.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp8_pkg;

    localparam int FP8_D_W    = 12;
    localparam int FP8_EXP_W  = 3;
    localparam int FP8_FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } fp8_state_t;

    // Golden decode: D = (-1)^S * (F << E), two's complement, FP8_D_W bits.
    function automatic logic [FP8_D_W-1:0] fp8_ref_decode(
        input logic                  s,
        input logic [FP8_EXP_W-1:0]  e,
        input logic [FP8_FRAC_W-1:0] f
    );
        logic [FP8_D_W-1:0] mag;
        mag = FP8_D_W'(f) << e;
        return s ? (FP8_D_W'(0) - mag) : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_to_linear_dec.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_linear_dec
//  Description : Sequential decoder from {S, E, F} float format to a
//                two's-complement linear value, one exponent step per clock,
//                with valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_to_linear_dec
    import fp8_pkg::*;
#(
    parameter int D_W    = FP8_D_W,
    parameter int EXP_W  = FP8_EXP_W,
    parameter int FRAC_W = FP8_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [FRAC_W-1:0] F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [D_W-1:0]    D,
    output logic              busy
);

    fp8_state_t       r_state;
    fp8_state_t       w_next_state;

    // Magnitude is held one bit narrower than D so the sign bit of the
    // result is always free; the largest value (15 << 7) fits without loss.
    logic [D_W-2:0]   r_mag;
    logic [EXP_W-1:0] r_cnt;
    logic             r_sign;
    logic [D_W-1:0]   r_d;
    logic             r_out_valid;

    logic [D_W-1:0]   w_pos;
    logic [D_W-1:0]   w_neg;

    // Negating zero wraps back to zero, so S=1/F=0 yields 0 without a special case.
    assign w_pos = {1'b0, r_mag};
    assign w_neg = ~w_pos + D_W'(1);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign D         = r_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one SHIFT edge per exponent step, then SIGN, then DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = (E != '0) ? SHIFT : SIGN;
                end
            end
            SHIFT: begin
                if (r_cnt == EXP_W'(1)) begin
                    w_next_state = SIGN;
                end
            end
            SIGN: begin
                w_next_state = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture operand on accept, shift/count, apply sign, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag  <= (D_W-1)'(F);
                        r_cnt  <= E;
                        r_sign <= S;
                    end
                end
                SHIFT: begin
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt - EXP_W'(1);
                end
                SIGN: begin
                    r_d         <= r_sign ? w_neg : w_pos;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_to_linear_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_to_linear_dec
//  Description : Directed self-checking bench for fp_to_linear_dec.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_linear_dec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;
    logic        busy;

    int checks;
    int errors;

    fp_to_linear_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction with out_ready held high: checks latency,
    // busy during the operation, result value and return to IDLE.
    task automatic run_op(input logic s, input logic [2:0] e, input logic [3:0] f,
                          input logic [11:0] exp_d, input string tag);
        int lat;
        bit busy_ok;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        S = s; E = e; F = f; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble operand after accept: result must not follow it.
        in_valid = 1'b0; S = ~s; E = ~e; F = ~f;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(e) + 32'd1);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_d"}, 32'(D), 32'(exp_d));
        @(posedge clk); #1;
        check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_d_hold"}, 32'(D), 32'(exp_d));
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S = 1'b0; E = 3'd0; F = 4'd0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        run_op(1'b0, 3'd0, 4'd5,  12'h005, "e0_f5");
        run_op(1'b0, 3'd7, 4'd15, 12'h780, "max_pos");
        run_op(1'b1, 3'd3, 4'd9,  12'hFB8, "neg72");
        run_op(1'b1, 3'd5, 4'd0,  12'h000, "neg_zero");
        run_op(1'b1, 3'd7, 4'd15, 12'h880, "max_neg");
        run_op(1'b0, 3'd4, 4'd3,  12'h030, "unnorm");

        // Backpressure: out_ready low, in_valid held high with the same operand
        @(negedge clk);
        S = 1'b0; E = 3'd1; F = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;                 // accept edge
        @(posedge clk); #1;                 // shift edge
        @(posedge clk); #1;                 // sign edge
        check("bp_ov", 32'(out_valid), 32'd1);
        check("bp_d", 32'(D), 32'h006);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_ov", 32'(out_valid), 32'd1);
            check("bp_hold_d", 32'(D), 32'h006);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;                 // output handshake
        out_ready = 1'b0;
        check("bp_hs_ov", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;                 // second operand accepted here
        in_valid = 1'b0;
        check("bp2_accepted", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("bp2_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp2_ov", 32'(out_valid), 32'd1);
        check("bp2_d", 32'(D), 32'h006);
        // out_ready ignored when nothing is valid: set it during the handshake only
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp2_done", 32'(in_ready), 32'd1);

        // Exhaustive sweep against the reference decode
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 8; e++) begin
                for (int f = 0; f < 16; f++) begin
                    run_op(1'(s), 3'(e), 4'(f),
                           fp8_pkg::fp8_ref_decode(1'(s), 3'(e), 4'(f)), "sweep");
                end
            end
        end

        // Reset two edges into SHIFT with E=6; D currently holds a nonzero result
        run_op(1'b0, 3'd3, 4'd1, 12'h008, "pre_rst");
        @(negedge clk);
        S = 1'b1; E = 3'd6; F = 4'd7; in_valid = 1'b1;
        @(posedge clk); #1;                 // accept
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_d", 32'(D), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_op(1'b0, 3'd2, 4'd8, 12'h020, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
